// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-access stage behind the execute ALU. It accepts one load or store at
// a time, issues a single aligned 32-bit bus transaction with byte strobes,
// and returns either a sign/zero-extended load result or a store completion.
//
// Ports:
//   clk, reset              single clock; synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_store, req_funct3   access kind and RISC-V width/sign field
//   req_addr, req_wdata     effective address and rs2 store data
//   mem_valid .. mem_wdata  registered bus request, held stable until mem_ready
//   mem_ready, mem_rdata    bus completion and read data
//   resp_valid              one-cycle completion pulse
//   resp_data               load result, 0 for stores, faulting address on fault
//   resp_fault              illegal request; no bus access was made
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses fault without a bus access
//   undefined -> misaligned accesses are silently aligned down
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  lo_reg;
    logic        store_reg;
    logic        mem_valid_reg;
    logic        mem_write_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] mem_wdata_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_data_reg;
    logic        resp_fault_reg;

    logic        legal;
    logic        fault_next;
    logic [31:0] wdata_next;
    logic [3:0]  wstrb_next;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_result;

    assign req_ready  = (state_reg == IDLE);
    assign mem_valid  = mem_valid_reg;
    assign mem_write  = mem_write_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wstrb  = mem_wstrb_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_fault = resp_fault_reg;

    // Request legality from funct3 (and alignment when trapping is enabled).
    always_comb begin
        legal = 1'b0;
        if (req_store) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                 legal = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign fault_next = !legal || misaligned;
`else
    assign fault_next = !legal;
`endif

    // Store lane replication and strobes. The half strobe shift uses only
    // addr[1], so a misaligned half naturally lands on the aligned-down pair.
    always_comb begin
        wdata_next = req_wdata;
        wstrb_next = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                wdata_next = {4{req_wdata[7:0]}};
                wstrb_next = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_next = {2{req_wdata[15:0]}};
                wstrb_next = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                wdata_next = req_wdata;
                wstrb_next = 4'b1111;
            end
        endcase
    end

    // Split read data into byte lanes for the load extractor.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte = rd_byte[lo_reg];
        sel_half = lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_result = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_result = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_result = {24'h000000, sel_byte};
            3'b101:  load_result = {16'h0000, sel_half};
            default: load_result = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            funct3_reg     <= 3'b000;
            lo_reg         <= 2'b00;
            store_reg      <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'h0;
            mem_wstrb_reg  <= 4'h0;
            mem_wdata_reg  <= 32'h0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 32'h0;
            resp_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        lo_reg     <= req_addr[1:0];
                        store_reg  <= req_store;
                        if (fault_next) begin
                            state_reg      <= DONE;
                            resp_valid_reg <= 1'b1;
                            resp_fault_reg <= 1'b1;
                            resp_data_reg  <= req_addr;
                        end else begin
                            state_reg     <= BUS;
                            mem_valid_reg <= 1'b1;
                            mem_write_reg <= req_store;
                            mem_addr_reg  <= {req_addr[31:2], 2'b00};
                            mem_wstrb_reg <= req_store ? wstrb_next : 4'h0;
                            mem_wdata_reg <= req_store ? wdata_next : 32'h0;
                        end
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        state_reg      <= DONE;
                        mem_valid_reg  <= 1'b0;
                        mem_write_reg  <= 1'b0;
                        mem_wstrb_reg  <= 4'h0;
                        resp_valid_reg <= 1'b1;
                        resp_fault_reg <= 1'b0;
                        resp_data_reg  <= store_reg ? 32'h0 : load_result;
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_fault_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
